// File: rtl/mem_stage_ls.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_ls
// Brief   : EX/MEM register, load align/extend and variable-latency SRAM wait.
// Revision: 1.0
// ============================================================================
module mem_stage_ls #(
  parameter int   STALL_W = 6,
  parameter int   STG     = 3,
  parameter int   RF_AW   = 5,
  parameter logic STOP    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [STALL_W-1:0] stall_i,
  input  logic [31:0]        ex_pc_i,
  input  logic               ex_ram_en_i,
  input  logic [3:0]         ex_ram_wen_i,
  input  logic [2:0]         ex_ld_type_i,
  input  logic               ex_rf_we_i,
  input  logic [RF_AW-1:0]   ex_rf_waddr_i,
  input  logic [31:0]        ex_result_i,
  input  logic [31:0]        data_sram_rdata_i,
  input  logic               data_sram_rvalid_i,
  output logic               stallreq_mem_o,
  output logic [31:0]        wb_pc_o,
  output logic               wb_rf_we_o,
  output logic [RF_AW-1:0]   wb_rf_waddr_o,
  output logic [31:0]        wb_rf_wdata_o,
  output logic               fwd_rf_we_o,
  output logic [RF_AW-1:0]   fwd_rf_waddr_o,
  output logic [31:0]        fwd_rf_wdata_o,
  output logic               fwd_ld_pend_o
);

  typedef struct packed {
    logic [31:0]      pc;
    logic             ram_en;
    logic [3:0]       ram_wen;
    logic [2:0]       ld_type;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [31:0]      result;
  } ex_mem_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  ex_mem_t     reg_q, reg_d;
  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;

  logic        w_stop_me, w_stop_nx, w_bubble, w_advance, w_reg_wr;
  logic        w_is_load, w_buf_valid;
  logic [1:0]  w_off;
  logic [31:0] w_raw, w_ext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_unused_stall;

  assign w_unused_stall = ^stall_i;

  assign w_stop_me = (stall_i[STG] == STOP);
  assign w_stop_nx = (stall_i[STG+1] == STOP);
  assign w_bubble  = w_stop_me & ~w_stop_nx;
  assign w_advance = ~w_stop_me;
  assign w_reg_wr  = flush_i | w_bubble | w_advance;

  // flush and bubble both empty the stage; otherwise advance captures EX
  always_comb begin
    reg_d = reg_q;
    if (flush_i || w_bubble) begin
      reg_d = '0;
    end else if (w_advance) begin
      reg_d.pc       = ex_pc_i;
      reg_d.ram_en   = ex_ram_en_i;
      reg_d.ram_wen  = ex_ram_wen_i;
      reg_d.ld_type  = ex_ld_type_i;
      reg_d.rf_we    = ex_rf_we_i;
      reg_d.rf_waddr = ex_rf_waddr_i;
      reg_d.result   = ex_result_i;
    end
  end

  assign w_is_load   = reg_q.ram_en & (reg_q.ram_wen == 4'b0000);
  assign w_buf_valid = (state_q == S_HOLD);

  // Read data is captured only when it arrives while the register is frozen.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    if (w_reg_wr) begin
      state_d = S_IDLE;
      buf_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_is_load) begin
            if (data_sram_rvalid_i) begin
              state_d = S_HOLD;
              buf_d   = data_sram_rdata_i;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (data_sram_rvalid_i) begin
            state_d = S_HOLD;
            buf_d   = data_sram_rdata_i;
          end
        end
        S_HOLD:  state_d = S_HOLD;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q   <= '0;
      state_q <= S_IDLE;
      buf_q   <= '0;
    end else begin
      reg_q   <= reg_d;
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  assign w_off = reg_q.result[1:0];
  assign w_raw = w_buf_valid ? buf_q : data_sram_rdata_i;

  always_comb begin
    w_byte = w_raw[7:0];
    case (w_off)
      2'd0:    w_byte = w_raw[7:0];
      2'd1:    w_byte = w_raw[15:8];
      2'd2:    w_byte = w_raw[23:16];
      default: w_byte = w_raw[31:24];
    endcase
  end

  // Halfword offset uses only off[1]; odd addresses are not trapped.
  assign w_half = w_off[1] ? w_raw[31:16] : w_raw[15:0];

  always_comb begin
    w_ext = w_raw;
    case (reg_q.ld_type)
      3'b001:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_ext = {24'b0, w_byte};
      3'b011:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {16'b0, w_half};
      default: w_ext = w_raw;
    endcase
  end

  assign stallreq_mem_o = w_is_load & ~w_buf_valid & ~data_sram_rvalid_i;

  assign wb_pc_o        = reg_q.pc;
  assign wb_rf_we_o     = reg_q.rf_we;
  assign wb_rf_waddr_o  = reg_q.rf_waddr;
  assign wb_rf_wdata_o  = w_is_load ? w_ext : reg_q.result;

  assign fwd_rf_we_o    = wb_rf_we_o;
  assign fwd_rf_waddr_o = wb_rf_waddr_o;
  assign fwd_rf_wdata_o = wb_rf_wdata_o;
  assign fwd_ld_pend_o  = stallreq_mem_o;

endmodule
`default_nettype wire
